mmul_seq: RTL and testbench

- Parametrised sequential signed fixed-point matrix multiplier: Res = A x B for square NxN matrices of Q(IW.FW) elements.
- Successor to the fixed 2x2 Q8.8 multiplier. Adds generic N/IW/FW, a single time-shared MAC, round-half-up plus saturation, a sticky overflow flag, and valid/ready handshakes on input and output.
- Sits between the matrix-operand staging logic and the result consumer.

---
 rtl/mmul_seq.sv | 112 +++++++++++
 tb/tb_mmul_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mmul_seq.sv
// rtl/mmul_seq.sv - sequential signed Q(IW.FW) NxN matrix multiplier on one time-shared MAC
module mmul_seq #(
  parameter int N  = 2,
  parameter int IW = 8,
  parameter int FW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*N*(IW+FW)-1:0]  a_in,
  input  logic [N*N*(IW+FW)-1:0]  b_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N*N*(IW+FW)-1:0]  res,
  output logic                    ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int W  = IW + FW;
  localparam int XW = $clog2(N);
  localparam int AW = 2*W + XW;
  localparam logic [XW-1:0] last = XW'(N-1);
  // rounding and saturation run one bit wider than acc so the +half can never wrap
  localparam logic signed [AW:0] half  = (AW+1)'(1) <<< (FW-1);
  localparam logic signed [AW:0] max_v = {{(AW-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW:0] min_v = ~max_v;

  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;
  state_t state, state_n;

  logic [N*N*W-1:0]      a_reg, b_reg;
  logic signed [AW-1:0]  acc;
  logic [XW-1:0]         i, j, k;

  logic signed [W-1:0]   a_el, b_el;
  logic signed [2*W-1:0] prod;
  logic signed [AW:0]    rnd, r;
  logic                  sat_hi, sat_lo;
  logic [W-1:0]          el;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    a_el   = a_reg[(int'(i)*N + int'(k))*W +: W];
    b_el   = b_reg[(int'(k)*N + int'(j))*W +: W];
    prod   = $signed({{W{a_el[W-1]}}, a_el}) * $signed({{W{b_el[W-1]}}, b_el});
    rnd    = $signed({acc[AW-1], acc}) + half;
    r      = rnd >>> FW;
    sat_hi = (r > max_v);
    sat_lo = (r < min_v);
    if (sat_hi)      el = {1'b0, {(W-1){1'b1}}};
    else if (sat_lo) el = {1'b1, {(W-1){1'b0}}};
    else             el = r[W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = CALC;
      CALC:    if (k == last) state_n = WRITE;
      WRITE:   state_n = (i == last && j == last) ? DONE : CALC;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      res   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a_in;
          b_reg <= b_in;
          acc   <= '0;
          i     <= '0;
          j     <= '0;
          k     <= '0;
          ovf   <= 1'b0;
        end
        CALC: begin
          acc <= acc + $signed({{XW{prod[2*W-1]}}, prod});
          k   <= (k == last) ? '0 : k + 1'b1;
        end
        WRITE: begin
          res[(int'(i)*N + int'(j))*W +: W] <= el;
          if (sat_hi || sat_lo) ovf <= 1'b1;
          acc <= '0;
          if (j == last) begin
            j <= '0;
            i <= (i == last) ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mmul_seq.sv
// tb/tb_mmul_seq.sv - directed self-checking bench for mmul_seq (N=2 and N=3 instances)
module tb_mmul_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [63:0]  a2 = '0, b2 = '0, res2;
  logic         iv2 = 1'b0, ir2, ov2, or2 = 1'b0, ovf2;
  logic [143:0] a3 = '0, b3 = '0, res3;
  logic         iv3 = 1'b0, ir3, ov3, or3 = 1'b0, ovf3;

  int total = 0;
  int bad   = 0;

  mmul_seq #(.N(2), .IW(8), .FW(8)) u2 (
    .clk(clk), .rst(rst), .a_in(a2), .b_in(b2), .in_valid(iv2), .in_ready(ir2),
    .res(res2), .ovf(ovf2), .out_valid(ov2), .out_ready(or2)
  );

  mmul_seq #(.N(3), .IW(8), .FW(8)) u3 (
    .clk(clk), .rst(rst), .a_in(a3), .b_in(b3), .in_valid(iv3), .in_ready(ir3),
    .res(res3), .ovf(ovf3), .out_valid(ov3), .out_ready(or3)
  );

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs are scrambled right after the accept edge to show they are not resampled
  task automatic run_job(input int n, input logic [143:0] a, input logic [143:0] b, input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    if (n == 2) begin a2 = a[63:0]; b2 = b[63:0]; iv2 = 1'b1; end
    else        begin a3 = a;       b3 = b;       iv3 = 1'b1; end
    @(posedge clk); #1;
    iv2 = 1'b0; iv3 = 1'b0;
    a2 = '1; b2 = '1; a3 = '1; b3 = '1;
    while (((n == 2) ? ov2 : ov3) !== 1'b1 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, " latency"}, 144'(cnt), 144'(n*n*(n+1)));
  endtask

  task automatic ack(input int n, input string tag);
    @(negedge clk);
    if (n == 2) or2 = 1'b1; else or3 = 1'b1;
    @(posedge clk); #1;
    or2 = 1'b0; or3 = 1'b0;
    check({tag, " in_ready after ack"}, (n == 2) ? ir2 : ir3, 1);
    check({tag, " out_valid after ack"}, (n == 2) ? ov2 : ov3, 0);
  endtask

  logic [143:0] id3, bm3;

  initial begin
    #2;
    check("reset in_ready", ir2, 1);
    check("reset out_valid", ov2, 0);
    check("reset res", res2, 0);
    check("reset ovf", ovf2, 0);
    check("reset in_ready n3", ir3, 1);
    @(negedge clk); rst = 1'b1;

    run_job(2, 64'h0000_0000_0000_0100 | 64'h0100_0000_0000_0000,
               64'h0200_0040_FF00_0180, "identity");
    check("identity res", res2, 64'h0200_0040_FF00_0180);
    check("identity ovf", ovf2, 0);
    check("identity in_ready in DONE", ir2, 0);
    ack(2, "identity");

    run_job(2, 64'h0080_0000_0000_FF00, 64'h0300_0000_0000_0200, "signed");
    check("signed res", res2, 64'h0180_0000_0000_FE00);
    check("signed ovf", ovf2, 0);
    ack(2, "signed");

    run_job(2, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0080, "round up");
    check("round up res", res2, 64'h0000_0000_0000_0001);
    ack(2, "round up");

    run_job(2, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0080, "round neg");
    check("round neg res", res2, 64'h0000_0000_0000_0000);
    ack(2, "round neg");

    run_job(2, 64'h7F00_7F00_7F00_7F00, 64'h7F00_7F00_7F00_7F00, "sat pos");
    check("sat pos res", res2, 64'h7FFF_7FFF_7FFF_7FFF);
    check("sat pos ovf", ovf2, 1);
    ack(2, "sat pos");

    run_job(2, 64'h8000_8000_8000_8000, 64'h7F00_7F00_7F00_7F00, "sat neg");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("backpressure res", res2, 64'h8000_8000_8000_8000);
      check("backpressure ovf", ovf2, 1);
      check("backpressure in_ready", ir2, 0);
      check("backpressure out_valid", ov2, 1);
    end
    ack(2, "sat neg");

    run_job(2, 64'h0100_0000_0000_0100, 64'h0200_0040_FF00_0180, "back2back");
    check("back2back res", res2, 64'h0200_0040_FF00_0180);
    check("back2back ovf cleared", ovf2, 0);
    ack(2, "back2back");

    // abort during CALC of element (0,1): third edge after accept enters it
    @(negedge clk);
    a2 = 64'h0080_0000_0000_FF00; b2 = 64'h0300_0000_0000_0200; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("midjob in_ready before reset", ir2, 0);
    rst = 1'b0;
    #1;
    check("async reset in_ready", ir2, 1);
    check("async reset out_valid", ov2, 0);
    check("async reset res", res2, 0);
    check("async reset ovf", ovf2, 0);
    @(negedge clk); rst = 1'b1;

    run_job(2, 64'h0080_0000_0000_FF00, 64'h0300_0000_0000_0200, "after reset");
    check("after reset res", res2, 64'h0180_0000_0000_FE00);
    check("after reset ovf", ovf2, 0);
    ack(2, "after reset");

    id3 = '0;
    bm3 = '0;
    for (int e = 0; e < 9; e++) begin
      bm3[e*16 +: 16] = 16'h1234 + 16'(e) * 16'h0F11;
      if (e % 4 == 0) id3[e*16 +: 16] = 16'h0100;
    end
    run_job(3, id3, bm3, "identity n3");
    check("identity n3 res", res3, bm3);
    check("identity n3 ovf", ovf3, 0);
    ack(3, "identity n3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
